// File: rtl/rgb_seq_pkg.sv
// Shared constants for the RGB fade sequencer: state encodings, the fixed
// colour table, the step-size sequence and the per-channel fade rule.
package rgb_seq_pkg;

  // State encodings
  localparam logic [1:0] FADE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  localparam int NUM_COLOURS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Fixed colour table, indexed by colour_idx
  function automatic rgb_t colour_of(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      3'd1:    c = '{r: 8'hFF, g: 8'h80, b: 8'h00};
      3'd2:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      3'd4:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      3'd5:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      3'd6:    c = '{r: 8'h80, g: 8'h00, b: 8'hFF};
      default: c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    endcase
    return c;
  endfunction

  // Step-size sequence 1 -> 2 -> 4 -> 8, selected by a 2-bit index
  function automatic logic [7:0] step_of(input logic [1:0] sel);
    logic [7:0] s;
    case (sel)
      2'd0:    s = 8'd1;
      2'd1:    s = 8'd2;
      2'd2:    s = 8'd4;
      default: s = 8'd8;
    endcase
    return s;
  endfunction

  // Move one channel a step toward its target, landing exactly on it when
  // within one step; the subtraction is only taken in the non-negative
  // direction, so the level never wraps through 0 or 255.
  function automatic logic [7:0] fade_channel(input logic [7:0] level,
                                              input logic [7:0] target,
                                              input logic [7:0] step);
    logic [7:0] nxt;
    if (level < target) begin
      nxt = ((target - level) <= step) ? target : (level + step);
    end else if (level > target) begin
      nxt = ((level - target) <= step) ? target : (level - step);
    end else begin
      nxt = level;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_debounce.sv
// Button conditioner: two-flop synchroniser, debounce counter that restarts
// whenever the synchronised input changes, and a one-cycle pulse on an
// accepted rising edge. A held button yields exactly one pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 120000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync_a;
  logic             sync_b;
  logic             sample_prev;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Bring the raw pin into the clock domain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has been steady long enough; emit a
  // pulse on the cycle a high level is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_prev <= 1'b0;
      stable      <= 1'b0;
      cnt         <= '0;
      pulse       <= 1'b0;
    end else begin
      pulse       <= 1'b0;
      sample_prev <= sync_b;
      if ((sync_b != sample_prev) || (sync_b == stable)) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable <= sync_b;
        cnt    <= '0;
        pulse  <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour sequencer driving rgb_led's control_* inputs. Fades the three
// channel levels toward the current colour-table entry on each tick, holds
// the reached colour, then advances. Buttons: next colour, pause, and step
// size. Any button pulse takes priority over a coincident tick, whose
// fade/hold update is then skipped. paused/fading decode the FSM state
// (HOLD is the case where both are 0).
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int CLOCK_FREQ   = 12000000,
  parameter int TICK_HZ      = 1000,
  parameter int DEBOUNCE_CYC = 120000,
  parameter int HOLD_TICKS   = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_pause,
  input  logic        btn_speed,
  output logic [15:0] control_red,
  output logic [15:0] control_grn,
  output logic [15:0] control_blu,
  output logic [2:0]  colour_idx,
  output logic        paused,
  output logic        fading
);

  localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int HOLD_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              next_p;
  logic              pause_p;
  logic              speed_p;

  logic [1:0]        state;
  logic [1:0]        ret_state;
  logic [1:0]        step_sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        level_red;
  logic [7:0]        level_grn;
  logic [7:0]        level_blu;

  logic [2:0]        next_idx;
  logic [7:0]        step;
  rgb_t              target;
  rgb_t              next_colour;
  rgb_t              faded;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clock (clock),
    .reset (reset),
    .btn   (btn_next),
    .pulse (next_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
    .clock (clock),
    .reset (reset),
    .btn   (btn_pause),
    .pulse (pause_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_speed (
    .clock (clock),
    .reset (reset),
    .btn   (btn_speed),
    .pulse (speed_p)
  );

  // Free-running tick divider; it keeps counting even while paused
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Targets and one-step-ahead channel levels for the current step size
  always_comb begin
    next_idx    = colour_idx + 3'd1;
    step        = step_of(step_sel);
    target      = colour_of(colour_idx);
    next_colour = colour_of(next_idx);
    faded.r     = fade_channel(level_red, target.r, step);
    faded.g     = fade_channel(level_grn, target.g, step);
    faded.b     = fade_channel(level_blu, target.b, step);
  end

  // Sequencer FSM with channel levels: pause beats next, any pulse beats tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FADE;
      ret_state  <= FADE;
      step_sel   <= 2'd0;
      hold_cnt   <= '0;
      colour_idx <= 3'd0;
      level_red  <= 8'h00;
      level_grn  <= 8'h00;
      level_blu  <= 8'h00;
    end else begin
      if (speed_p) begin
        step_sel <= step_sel + 2'd1;
      end
      if (pause_p) begin
        if (state == PAUSED) begin
          state <= ret_state;
        end else begin
          ret_state <= state;
          state     <= PAUSED;
        end
      end else if (next_p) begin
        colour_idx <= next_idx;
        hold_cnt   <= '0;
        if (state == PAUSED) begin
          // Jump straight to the new colour and resume into its hold phase
          level_red <= next_colour.r;
          level_grn <= next_colour.g;
          level_blu <= next_colour.b;
          ret_state <= HOLD;
        end else begin
          state <= FADE;
        end
      end else if (tick && !speed_p) begin
        case (state)
          FADE: begin
            level_red <= faded.r;
            level_grn <= faded.g;
            level_blu <= faded.b;
            if (faded == target) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
              colour_idx <= next_idx;
              hold_cnt   <= '0;
              state      <= FADE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign control_red = {8'h00, level_red};
  assign control_grn = {8'h00, level_grn};
  assign control_blu = {8'h00, level_blu};
  assign paused      = (state == PAUSED);
  assign fading      = (state == FADE);

endmodule
